// File: rtl/fmpadding_pkg.sv
// Shared definitions for the dilating feature-map padder: register map,
// per-axis geometry record and pad-beat builder.
package fmpadding_pkg;

  localparam logic [3:0] ADDR_XON    = 4'd0;
  localparam logic [3:0] ADDR_XOFF   = 4'd1;
  localparam logic [3:0] ADDR_XEND   = 4'd2;
  localparam logic [3:0] ADDR_XDIL   = 4'd3;
  localparam logic [3:0] ADDR_YON    = 4'd4;
  localparam logic [3:0] ADDR_YOFF   = 4'd5;
  localparam logic [3:0] ADDR_YEND   = 4'd6;
  localparam logic [3:0] ADDR_YDIL   = 4'd7;
  localparam logic [3:0] ADDR_PADVAL = 4'd8;

  // Fields are zero-extended from each axis' counter width to this width.
  localparam int unsigned DIM_BITS     = 16;
  localparam int unsigned PAD_MAX_BITS = 256;

  typedef struct packed {
    logic [DIM_BITS-1:0] on;
    logic [DIM_BITS-1:0] off;
    logic [DIM_BITS-1:0] end_pos;
    logic [DIM_BITS-1:0] dil;
  } dim_cfg_t;

  // Replicate the pad element into every SIMD lane; bits above the lanes stay zero.
  function automatic logic [PAD_MAX_BITS-1:0] pad_beat(input logic [DIM_BITS-1:0] pad_val,
                                                      input int unsigned simd,
                                                      input int unsigned elem_bits);
    logic [PAD_MAX_BITS-1:0] beat;
    logic [DIM_BITS-1:0]     mask;
    mask = (DIM_BITS'(1) << elem_bits) - DIM_BITS'(1);
    beat = '0;
    for (int unsigned i = 0; i < simd; i++) begin
      beat = beat | (PAD_MAX_BITS'(pad_val & mask) << (i * elem_bits));
    end
    return beat;
  endfunction

endpackage

// File: rtl/fmpadding_axis_dim.sv
// One image axis: position counter 0..end_pos and dilation phase counter
// that restarts at the first interior position.
module fmpadding_axis_dim
  import fmpadding_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     step,
  input  dim_cfg_t cfg,
  output logic     active,
  output logic     last
);

  logic [W-1:0] pos;
  logic [W-1:0] phase;
  logic [W-1:0] pos_nxt;
  logic [W-1:0] phase_nxt;
  logic         in_range;

  always_comb begin
    in_range  = (DIM_BITS'(pos) >= cfg.on) && (DIM_BITS'(pos) < cfg.off);
    last      = (DIM_BITS'(pos) == cfg.end_pos);
    active    = in_range && (phase == '0);
    pos_nxt   = last ? '0 : pos + W'(1);
    phase_nxt = phase;
    if (in_range) begin
      phase_nxt = (DIM_BITS'(phase) == cfg.dil) ? '0 : phase + W'(1);
    end
    // Entering the interior always lands on a data phase.
    if (DIM_BITS'(pos_nxt) == cfg.on) begin
      phase_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      phase <= '0;
    end else if (step) begin
      pos   <= pos_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/fmpadding_dilate_axi.sv
// AXI-Stream feature-map padder with interior dilation, programmable pad
// value and per-image shadowed geometry.
module fmpadding_dilate_axi
  import fmpadding_pkg::*;
#(
  parameter  int unsigned XCOUNTER_BITS = 8,
  parameter  int unsigned YCOUNTER_BITS = 8,
  parameter  int unsigned NUM_CHANNELS  = 4,
  parameter  int unsigned SIMD          = 2,
  parameter  int unsigned ELEM_BITS     = 4,
  localparam int unsigned STREAM_BITS   = 8 * (1 + (SIMD * ELEM_BITS - 1) / 8)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   we,
  input  logic [3:0]             wa,
  input  logic [31:0]            wd,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [STREAM_BITS-1:0] s_axis_tdata,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [STREAM_BITS-1:0] m_axis_tdata
);

  localparam int unsigned CF_COUNT = NUM_CHANNELS / SIMD;
  localparam int unsigned CF_BITS  = (CF_COUNT > 1) ? $clog2(CF_COUNT) : 1;
  localparam logic [CF_BITS-1:0] CF_LAST = CF_BITS'(CF_COUNT - 1);

  dim_cfg_t             live_x, live_y, act_x, act_y, cfg_x, cfg_y;
  logic [ELEM_BITS-1:0] live_pad, act_pad, cfg_pad;
  logic                 pending;
  logic [CF_BITS-1:0]   cf;
  logic                 ovld;
  logic [STREAM_BITS-1:0] odat;
  logic                 x_active, x_last, y_active, y_last;
  logic                 cf_last, consume, can_issue, issue, step_x, step_y, img_last;
  logic                 unused_wd;

  assign unused_wd = &{1'b0, wd};

  // Live registers have no reset; the active set follows them until an image starts.
  always_ff @(posedge ap_clk) begin
    if (we) begin
      case (wa)
        ADDR_XON:    live_x.on      <= DIM_BITS'(wd[XCOUNTER_BITS-1:0]);
        ADDR_XOFF:   live_x.off     <= DIM_BITS'(wd[XCOUNTER_BITS-1:0]);
        ADDR_XEND:   live_x.end_pos <= DIM_BITS'(wd[XCOUNTER_BITS-1:0]);
        ADDR_XDIL:   live_x.dil     <= DIM_BITS'(wd[XCOUNTER_BITS-1:0]);
        ADDR_YON:    live_y.on      <= DIM_BITS'(wd[YCOUNTER_BITS-1:0]);
        ADDR_YOFF:   live_y.off     <= DIM_BITS'(wd[YCOUNTER_BITS-1:0]);
        ADDR_YEND:   live_y.end_pos <= DIM_BITS'(wd[YCOUNTER_BITS-1:0]);
        ADDR_YDIL:   live_y.dil     <= DIM_BITS'(wd[YCOUNTER_BITS-1:0]);
        ADDR_PADVAL: live_pad       <= wd[ELEM_BITS-1:0];
        default: ;
      endcase
    end
    if (pending) begin
      act_x   <= live_x;
      act_y   <= live_y;
      act_pad <= live_pad;
    end
  end

  // Before the first beat of an image, decisions use the live set directly.
  assign cfg_x   = pending ? live_x   : act_x;
  assign cfg_y   = pending ? live_y   : act_y;
  assign cfg_pad = pending ? live_pad : act_pad;

  fmpadding_axis_dim #(.W(XCOUNTER_BITS)) u_dim_x (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .step   (step_x),
    .cfg    (cfg_x),
    .active (x_active),
    .last   (x_last)
  );

  fmpadding_axis_dim #(.W(YCOUNTER_BITS)) u_dim_y (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .step   (step_y),
    .cfg    (cfg_y),
    .active (y_active),
    .last   (y_last)
  );

  assign cf_last       = (cf == CF_LAST);
  assign consume       = x_active && y_active;
  assign can_issue     = !ovld || m_axis_tready;
  assign s_axis_tready = ap_rst_n && consume && can_issue;
  assign issue         = can_issue && (!consume || s_axis_tvalid);
  assign step_x        = issue && cf_last;
  assign step_y        = step_x && x_last;
  assign img_last      = step_y && y_last;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cf      <= '0;
      pending <= 1'b1;
      ovld    <= 1'b0;
      odat    <= '0;
    end else begin
      if (issue) begin
        cf      <= cf_last ? '0 : cf + CF_BITS'(1);
        pending <= img_last;
        ovld    <= 1'b1;
        odat    <= consume ? s_axis_tdata
                           : STREAM_BITS'(pad_beat(DIM_BITS'(cfg_pad), SIMD, ELEM_BITS));
      end else if (m_axis_tready) begin
        ovld <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = ovld;
  assign m_axis_tdata  = odat;

endmodule

// File: tb/tb_fmpadding_dilate_axi.sv
// Bench for fmpadding_dilate_axi: table of geometries plus hand-written
// shadowing, backpressure and mid-image reset sequences against a pixel-level model.
module tb_fmpadding_dilate_axi;

  localparam int SIMD = 2;
  localparam int ELEM_BITS = 4;
  localparam int NUM_CHANNELS = 4;
  localparam int CF = NUM_CHANNELS / SIMD;
  localparam int LIMIT = 20000;
  localparam int BIG = 1 << 30;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic       we;
  logic [3:0] wa;
  logic [31:0] wd;
  logic       s_axis_tready, s_axis_tvalid, m_axis_tready, m_axis_tvalid;
  logic [7:0] s_axis_tdata, m_axis_tdata;

  fmpadding_dilate_axi #(
    .XCOUNTER_BITS(8), .YCOUNTER_BITS(8), .NUM_CHANNELS(NUM_CHANNELS),
    .SIMD(SIMD), .ELEM_BITS(ELEM_BITS)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .we(we), .wa(wa), .wd(wd),
    .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int xon, xoff, xend, xdil, yon, yoff, yend, ydil, pad;
  } geom_t;

  typedef struct {
    geom_t g;
    int    images;
    bit    full;
    bit    ascending;
    int    exp_out;
    int    exp_in;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;
  int in_idx, last_cyc, model_ptr;
  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  vec_t vecs[6];
  geom_t g1, g_shadow, g_rst;

  function automatic geom_t mk(int xon, int xoff, int xend, int xdil,
                               int yon, int yoff, int yend, int ydil, int pad);
    geom_t g;
    g.xon = xon; g.xoff = xoff; g.xend = xend; g.xdil = xdil;
    g.yon = yon; g.yoff = yoff; g.yend = yend; g.ydil = ydil; g.pad = pad;
    return g;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Output stream of one image, pixel by pixel, straight from the geometry rules.
  task automatic model_image(input geom_t g);
    logic [7:0] pb;
    bit cx, cy;
    pb = 8'h00;
    for (int l = 0; l < SIMD; l++) pb = pb | 8'((g.pad & 15) << (l * ELEM_BITS));
    for (int y = 0; y <= g.yend; y++)
      for (int x = 0; x <= g.xend; x++)
        for (int c = 0; c < CF; c++) begin
          cx = (x >= g.xon) && (x < g.xoff) && (((x - g.xon) % (g.xdil + 1)) == 0);
          cy = (y >= g.yon) && (y < g.yoff) && (((y - g.yon) % (g.ydil + 1)) == 0);
          if (cx && cy) begin
            exp_q.push_back(in_q[model_ptr]);
            model_ptr++;
          end else begin
            exp_q.push_back(pb);
          end
        end
  endtask

  task automatic fill_inputs(input bit ascending);
    in_q.delete();
    exp_q.delete();
    model_ptr = 0;
    for (int i = 0; i < 512; i++) in_q.push_back(ascending ? 8'(i) : 8'($urandom));
  endtask

  task automatic trim_inputs();
    while (in_q.size() > model_ptr) void'(in_q.pop_back());
  endtask

  task automatic wreg(input logic [3:0] a, input int v, input int w);
    @(negedge ap_clk);
    we = 1'b1;
    wa = a;
    wd = ($urandom() << w) | 32'(v);
    @(negedge ap_clk);
    we = 1'b0;
  endtask

  // Program a geometry while reset is held; upper data bits carry junk.
  task automatic cfg_in_reset(input geom_t g);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    wreg(4'd0, g.xon, 8);  wreg(4'd1, g.xoff, 8); wreg(4'd2, g.xend, 8); wreg(4'd3, g.xdil, 8);
    wreg(4'd4, g.yon, 8);  wreg(4'd5, g.yoff, 8); wreg(4'd6, g.yend, 8); wreg(4'd7, g.ydil, 8);
    wreg(4'd8, g.pad, 4);
  endtask

  // Entered at a negedge; drives, settles, scores one cycle per iteration.
  task automatic run(input bit full, input int stop, input int stall_at, input int wr_at);
    int out_cnt, cyc, stall_cnt, wr_i;
    bit in_stall;
    out_cnt = 0; cyc = 0; stall_cnt = 0; wr_i = 0; in_idx = 0;
    while (out_cnt < stop && exp_q.size() > 0 && cyc < LIMIT) begin
      in_stall = 1'b0;
      if (stall_at >= 0 && out_cnt >= stall_at && stall_cnt < 10) begin
        stall_cnt++;
        in_stall = 1'b1;
        m_axis_tready = 1'b0;
        s_axis_tvalid = (in_idx < in_q.size());
      end else begin
        m_axis_tready = full || ($urandom_range(3) != 0);
        s_axis_tvalid = (in_idx < in_q.size()) && (full || ($urandom_range(3) != 0));
      end
      if (s_axis_tvalid) s_axis_tdata = in_q[in_idx];
      else s_axis_tdata = 8'($urandom);
      if (wr_at >= 0 && out_cnt >= wr_at && wr_i < 2) begin
        we = 1'b1;
        wa = (wr_i == 0) ? 4'd0 : 4'd1;
        wd = (wr_i == 0) ? 32'd0 : 32'd10;
        wr_i++;
      end else begin
        we = 1'b0;
      end
      #1;
      if (in_stall && stall_cnt >= 2) begin
        check("bp_tvalid", 32'(m_axis_tvalid), 1);
        check("bp_tdata", 32'(m_axis_tdata), 32'(exp_q[0]));
        check("bp_s_tready", 32'(s_axis_tready), 0);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check($sformatf("beat%0d", out_cnt), 32'(m_axis_tdata), 32'(exp_q.pop_front()));
        out_cnt++;
      end
      if (s_axis_tvalid && s_axis_tready) in_idx++;
      cyc++;
      @(negedge ap_clk);
    end
    check("run_timeout", 32'(cyc >= LIMIT), 0);
    last_cyc = cyc;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;

    g1       = mk(2, 7, 9, 0, 1, 5, 6, 0, 0);
    g_shadow = mk(0, 10, 9, 0, 1, 5, 6, 0, 0);
    g_rst    = mk(0, 5, 6, 0, 0, 3, 3, 0, 6);
    vecs[0] = '{g: g1,                                images: 2, full: 0, ascending: 1, exp_out: 280, exp_in: 80};
    vecs[1] = '{g: mk(1, 6, 6, 1, 0, 3, 2, 1, 0),     images: 1, full: 0, ascending: 0, exp_out: 42,  exp_in: 12};
    vecs[2] = '{g: mk(2, 7, 9, 0, 1, 5, 6, 0, 10),    images: 1, full: 0, ascending: 0, exp_out: 140, exp_in: 40};
    vecs[3] = '{g: mk(3, 3, 4, 0, 0, 2, 1, 0, 5),     images: 1, full: 0, ascending: 0, exp_out: 20,  exp_in: 0};
    vecs[4] = '{g: mk(0, 5, 5, 2, 1, 4, 4, 1, 3),     images: 2, full: 0, ascending: 0, exp_out: 120, exp_in: 16};
    vecs[5] = '{g: g1,                                images: 2, full: 1, ascending: 1, exp_out: 280, exp_in: 80};

    #12;
    check("rst_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_tdata", 32'(m_axis_tdata), 0);
    check("rst_s_tready", 32'(s_axis_tready), 0);

    foreach (vecs[i]) begin
      cfg_in_reset(vecs[i].g);
      fill_inputs(vecs[i].ascending);
      repeat (vecs[i].images) model_image(vecs[i].g);
      trim_inputs();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      run(vecs[i].full, BIG, -1, -1);
      check($sformatf("v%0d_consumed", i), in_idx, vecs[i].exp_in);
      if (vecs[i].full) check($sformatf("v%0d_cycles", i), last_cyc, vecs[i].exp_out + 1);
    end

    // Mid-image rewrite of XOn/XOff only takes effect on the following image.
    cfg_in_reset(g1);
    fill_inputs(1'b0);
    model_image(g1);
    model_image(g_shadow);
    trim_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run(1'b0, BIG, -1, 50);
    check("shadow_consumed", in_idx, 120);

    // Output held for ten cycles in the middle of a row.
    cfg_in_reset(g1);
    fill_inputs(1'b0);
    model_image(g1);
    trim_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run(1'b0, BIG, 30, -1);
    check("bp_consumed", in_idx, 40);

    // Asynchronous reset mid-image, then a fresh image on the retained config.
    cfg_in_reset(g_rst);
    fill_inputs(1'b0);
    model_image(g_rst);
    trim_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run(1'b0, 30, -1, -1);
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'($urandom);
    @(negedge ap_clk);
    #1;
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(m_axis_tvalid), 0);
    check("async_rst_tdata", 32'(m_axis_tdata), 0);
    check("async_rst_s_tready", 32'(s_axis_tready), 0);
    s_axis_tvalid = 1'b0;
    fill_inputs(1'b0);
    model_image(g_rst);
    trim_inputs();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run(1'b0, BIG, -1, -1);
    check("post_rst_consumed", in_idx, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
